// File: rtl/midi_pkg.sv
// Shared constants and state types for the MIDI note receiver.
package midi_pkg;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [7:0] RT_MIN   = 8'hF8;
  localparam logic [7:0] SYS_MIN  = 8'hF0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  typedef enum logic [1:0] {NO_STATUS, DATA1, DATA2} parse_phase_e;

  // 7-bit velocity stretched to the 10-bit amp range
  function automatic logic [9:0] amp_of(input logic [6:0] v);
    return {v, v[6:4]};
  endfunction
endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial byte receiver with 2-FF input synchronizer and mid-bit sampling.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKSPEED = 48_000_000,
  parameter int BAUD     = 31250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int DIV = CLKSPEED / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  rx_state_e     state, state_n;
  logic          rx_meta, rx_s, wait_hi, bit_done;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_comb begin
    state_n  = state;
    bit_done = 1'b0;
    case (state)
      IDLE:  if (!rx_s && !wait_hi) state_n = START;
      START: begin
        bit_done = (cnt == HALF);
        if (bit_done) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        bit_done = (cnt == FULL);
        if (bit_done && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        bit_done = (cnt == FULL);
        if (bit_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      wait_hi    <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      state      <= state_n;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= (state == IDLE || bit_done) ? '0 : cnt + 1'b1;
      if (state == IDLE && rx_s) wait_hi <= 1'b0;
      if (state == START) bit_idx <= '0;
      if (state == DATA && bit_done) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      // A low stop bit means we may be mid-frame: hold off until the line idles
      if (state == STOP && bit_done) begin
        if (rx_s) begin
          data       <= shreg;
          byte_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          wait_hi   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/midi_note_rx.sv
// MIDI Note On/Off decoder driving a monophonic note/velocity/gate/amp interface.
module midi_note_rx
  import midi_pkg::*;
#(
  parameter int CLKSPEED = 48_000_000,
  parameter int BAUD     = 31250,
  parameter int CHANNEL  = 0,
  parameter int OMNI     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic [9:0] amp,
  output logic       note_valid,
  output logic       frame_err
);
  logic [7:0]   rx_byte, status;
  logic [6:0]   key, vel_in;
  logic         byte_valid, status_wr, key_wr, msg_done, chan_ok, is_on, is_off;
  parse_phase_e phase, phase_n;

  midi_uart_rx #(.CLKSPEED(CLKSPEED), .BAUD(BAUD)) u_uart (
    .clk(clk), .rst(rst), .rx(rx),
    .data(rx_byte), .byte_valid(byte_valid), .frame_err(frame_err)
  );

  assign vel_in  = rx_byte[6:0];
  assign chan_ok = (OMNI != 0) || (status[3:0] == 4'(CHANNEL));
  assign is_on   = (status[7:4] == NOTE_ON);
  assign is_off  = (status[7:4] == NOTE_OFF);

  // Real-time bytes fall through untouched so they can sit between key and vel
  always_comb begin
    phase_n   = phase;
    status_wr = 1'b0;
    key_wr    = 1'b0;
    msg_done  = 1'b0;
    if (byte_valid && rx_byte < RT_MIN) begin
      if (rx_byte >= SYS_MIN) phase_n = NO_STATUS;
      else if (rx_byte[7]) begin
        status_wr = 1'b1;
        phase_n   = DATA1;
      end else begin
        case (phase)
          DATA1: begin key_wr = 1'b1; phase_n = DATA2; end
          DATA2: begin msg_done = 1'b1; phase_n = DATA1; end
          default: phase_n = phase;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= NO_STATUS;
      status     <= '0;
      key        <= '0;
      note       <= '0;
      velocity   <= '0;
      gate       <= 1'b0;
      amp        <= '0;
      note_valid <= 1'b0;
    end else begin
      phase      <= phase_n;
      note_valid <= 1'b0;
      if (status_wr) status <= rx_byte;
      if (key_wr) key <= rx_byte[6:0];
      if (msg_done && chan_ok) begin
        if (is_on && vel_in != 7'd0) begin
          note       <= key;
          velocity   <= vel_in;
          gate       <= 1'b1;
          amp        <= amp_of(vel_in);
          note_valid <= 1'b1;
        end else if ((is_on || is_off) && gate && key == note) begin
          gate       <= 1'b0;
          velocity   <= '0;
          amp        <= '0;
          note_valid <= 1'b1;
        end
      end
    end
  end
endmodule
